// File: rtl/guitar_event_fifo_pkg.sv
// guitar_event_fifo_pkg: shared event word geometry for the guitar input path
package guitar_event_fifo_pkg;
    localparam int EVT_WIDTH      = 8;
    localparam int EVT_FIFO_DEPTH = 8;
    localparam int EVT_BTN_LSB    = 0;
    localparam int EVT_BTN_MSB    = 6;
    localparam int EVT_STRUM_BIT  = 7;

    typedef struct packed {
        logic       strum;
        logic [6:0] buttons;
    } evt_t;

    function automatic logic evt_strum(input logic [EVT_WIDTH-1:0] w);
        return w[EVT_STRUM_BIT];
    endfunction
endpackage

// File: rtl/guitar_event_fifo_if.sv
// guitar_event_fifo_if: push/pop/status bundle between synchronizer, processor MMIO and the event FIFO
interface guitar_event_fifo_if #(parameter int WIDTH = 8, parameter int DEPTH = 8);
    localparam int CW = $clog2(DEPTH) + 1;
    logic             wr_en;
    logic [WIDTH-1:0] wr_data;
    logic             rd_en;
    logic [WIDTH-1:0] rd_data;
    logic             empty;
    logic             full;
    logic [CW-1:0]    count;
    logic             overflow;
    logic             ovf_ack;

    modport master(output wr_en, wr_data, rd_en, ovf_ack, input rd_data, empty, full, count, overflow);
    modport slave(input wr_en, wr_data, rd_en, ovf_ack, output rd_data, empty, full, count, overflow);
endinterface

// File: rtl/guitar_event_fifo_fifo_ptr.sv
// fifo_ptr: wrapping pointer with increment enable and async clear
module fifo_ptr #(parameter int W = 3) (
    input  logic         clk,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);
    always_ff @(posedge clk or posedge clr)
        if (clr) q <= '0;
        else if (inc) q <= q + W'(1);
endmodule

// File: rtl/guitar_event_fifo.sv
// guitar_event_fifo: show-ahead event FIFO with explicit count and sticky overflow flag
module guitar_event_fifo
    import guitar_event_fifo_pkg::*;
#(
    parameter int WIDTH = EVT_WIDTH,
    parameter int DEPTH = EVT_FIFO_DEPTH
) (
    input logic clk,
    input logic clr,
    guitar_event_fifo_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wp, rp;
    logic [CW-1:0]    cnt;
    logic             ovf, empty, full, push, pop, drop;

    assign empty = cnt == '0;
    assign full  = cnt == CW'(DEPTH);
    // a simultaneous pop frees the slot, so a full FIFO still takes the push
    assign push  = bus.wr_en && (!full || bus.rd_en);
    assign pop   = bus.rd_en && !empty;
    assign drop  = bus.wr_en && full && !bus.rd_en;

    fifo_ptr #(.W(AW)) u_wp (.clk(clk), .clr(clr), .inc(push), .q(wp));
    fifo_ptr #(.W(AW)) u_rp (.clk(clk), .clr(clr), .inc(pop),  .q(rp));

    always_ff @(posedge clk or posedge clr)
        if (clr) begin
            mem <= '{default: '0};
            cnt <= '0;
            ovf <= 1'b0;
        end else begin
            if (push) mem[wp] <= bus.wr_data;
            cnt <= (push && !pop) ? cnt + CW'(1) : (pop && !push) ? cnt - CW'(1) : cnt;
            ovf <= drop || (ovf && !bus.ovf_ack);
        end

    assign bus.rd_data  = mem[rp];
    assign bus.empty    = empty;
    assign bus.full     = full;
    assign bus.count    = cnt;
    assign bus.overflow = ovf;
endmodule

// File: doc/guitar_event_fifo.md
# guitar_event_fifo

Buffers guitar button/strum events between the input synchronizer and the processor's memory-mapped I/O read path. The synchronizer pushes one event word per cycle at most; the processor pops one per load instruction. The block decouples bursty guitar input from processor polling and flags lost events. Show-ahead FIFO: the head entry is always visible on `rd_data`.

## Interface
Parameters:
- `WIDTH`, 8, event word width (button bitmap plus strum bit)
- `DEPTH`, 8, number of entries; must be a power of two, at least 2

Ports:
- `clk`  in  1  single system clock; all state updates on posedge
- `clr`  in  1  reset, asynchronous, active-high
- `wr_en`  in  1  push request from synchronizer
- `wr_data`  in  WIDTH  event word to push
- `rd_en`  in  1  pop request from processor MMIO load
- `rd_data`  out  WIDTH  head entry (show-ahead)
- `empty`  out  1  no entries held
- `full`  out  1  DEPTH entries held
- `count`  out  log2(DEPTH)+1  entries held, 0..DEPTH
- `overflow`  out  1  sticky: a push was dropped while full
- `ovf_ack`  in  1  clears `overflow`

## Operation
- Storage: DEPTH x WIDTH registers, write pointer `wp` and read pointer `rp`, each log2(DEPTH) bits, wrapping modulo DEPTH. `count` is held as its own register.
- Push accepted when `wr_en && (!full || rd_en)`. Accepted push: `mem[wp] <= wr_data`, `wp <= wp+1`.
- Pop accepted when `rd_en && !empty`. Accepted pop: `rp <= rp+1`.
- `count` changes by +1 on push only, by -1 on pop only, and stays unchanged when both or neither are accepted.
- Full with push and pop in the same cycle: both are accepted, `count` stays at DEPTH, and `overflow` is not set.
- Empty with push and pop in the same cycle: the push is accepted and the pop is ignored. There is no fall-through, and `count` becomes 1.
- Pop while empty: ignored. Pointers and `count` stay unchanged.
- Push while full without a pop: the data is dropped and `overflow <= 1`.
- `ovf_ack`: `overflow <= 0`. If a drop happens in the same cycle, set wins and `overflow` stays 1.
- `rd_data = mem[rp]`, combinational from registered state. The value is meaningless when `empty`, but is deterministic.
- Decodes: `empty = (count==0)`, `full = (count==DEPTH)`.

## Timing
- Reset (`clr` high, any time, including mid-burst) takes effect immediately with no clock edge:
  - `wp`, `rp`, `count` = 0; `empty`=1; `full`=0; `overflow`=0
  - every `mem` entry = 0, so `rd_data`=0
- Push-to-visible latency is 1 cycle: a word pushed into an empty FIFO at edge N appears on `rd_data` after edge N, with `empty`=0 in cycle N+1.
- A pop at edge N presents the next entry on `rd_data` after edge N.
- Throughput is one push and one pop per cycle.
- `full`, `empty`, `count` and `overflow` all reflect state after the most recent edge.
- When `clr` deasserts, the first active edge is the next posedge.

## Structure
- The shared I/O package holds:
  - `EVT_WIDTH` = 8
  - `EVT_FIFO_DEPTH` = 8
  - the event word bit-field positions: buttons [6:0], strum [7]
- Sub-module `fifo_ptr`: a log2(DEPTH)-bit wrapping counter with increment enable and asynchronous `clr`. It is instantiated twice, once each for `wp` and `rp`.
- Storage and `count` logic live in the top module.

## Test plan
- Reset, then 8 pushes of 0x01..0x08: `full`=1, `count`=8. Then 8 pops: `rd_data` is 0x01..0x08 in order, and `empty`=1 at the end.
- Fill, then one cycle with `wr_en`=1 (0xAA) and `rd_en`=1: `count` stays 8 and `overflow`=0. Drain: the last word is 0xAA.
- Fill, then push 0x55 without a pop: `overflow`=1 and `count`=8; 0x55 is never read. Assert `ovf_ack` for one cycle: `overflow`=0. Assert `ovf_ack` together with another dropped push: `overflow` stays 1.
- Empty, then `wr_en`=1 (0x3C) and `rd_en`=1 in the same cycle: `count`=1, `rd_data`=0x3C next cycle. Then pop while empty: no pointer change and `count` stays 0.
- Wrap-around: 20 interleaved push/pop pairs with a running counter value: data order is preserved across pointer wrap and `count` never exceeds 1.
- Push 3 words, then assert `clr` asynchronously between edges: outputs go to reset values immediately. A push after release reads back correctly.
